// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, multi-cycle mul/div and taken-branch bubbles.
// Enables and flushes are combinational from state, cnt and inputs; stall_cnt_o is registered.
module hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int LOAD_LAT    = 1,
  parameter int MD_LAT      = 4,
  parameter int BR_FLUSH_EX = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       instr_i,
  input  logic              idex_memread,
  input  logic [REG_AW-1:0] idex_regt,
  input  logic              branch_taken,
  input  logic              md_start,
  output logic              pcwrite,
  output logic              ifid_write,
  output logic              idex_write,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic [15:0]       stall_cnt_o
);

  localparam int CW = $clog2(32);
  localparam logic [CW-1:0] LD_RELOAD = (LOAD_LAT >= 2) ? CW'(LOAD_LAT - 2) : '0;
  localparam logic [CW-1:0] MD_RELOAD = (MD_LAT >= 2) ? CW'(MD_LAT - 2) : '0;
  localparam logic LD_MULTI = (LOAD_LAT >= 2);
  localparam logic MD_MULTI = (MD_LAT >= 2);
  localparam logic BR_EX    = (BR_FLUSH_EX != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_STALL,
    S_MD_BUSY
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [15:0]       r_stall_cnt;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic              w_hit;
  logic              w_unused_instr;

  assign w_rs  = REG_AW'(instr_i[25:21]);
  assign w_rt  = REG_AW'(instr_i[20:16]);
  assign w_hit = idex_memread && (idex_regt != '0) &&
                 ((idex_regt == w_rs) || (idex_regt == w_rt));
  assign w_unused_instr = ^{instr_i[31:26], instr_i[15:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Branch wins in IDLE and LOAD_STALL; MD_BUSY runs to completion regardless of inputs.
  always_comb begin
    pcwrite     = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = BR_EX;
        end else if (md_start && MD_MULTI) begin
          pcwrite     = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_flush = 1'b1;
          w_cnt_nxt   = MD_RELOAD;
          w_state_nxt = S_MD_BUSY;
        end else if (w_hit) begin
          pcwrite    = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          if (LD_MULTI) begin
            w_cnt_nxt   = LD_RELOAD;
            w_state_nxt = S_LOAD_STALL;
          end
        end
      end
      S_LOAD_STALL: begin
        if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = BR_EX;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          pcwrite    = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          if (r_cnt == '0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      end
      S_MD_BUSY: begin
        if (r_cnt != '0) begin
          pcwrite     = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_flush = 1'b1;
          w_cnt_nxt   = r_cnt - 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (!pcwrite && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_LAT 3/MD_LAT 4 and LOAD_LAT 4/MD_LAT 1)
// checked every cycle against a stall-budget model plus directed literal checks.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        memread = 1'b0;
  logic [4:0]  regt = '0;
  logic        branch = 1'b0;
  logic        md = 1'b0;
  logic [5:0]  fl_a;
  logic [5:0]  fl_b;
  logic [15:0] sc_a;
  logic [15:0] sc_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .MD_LAT(4), .BR_FLUSH_EX(1)) u_a (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .idex_memread(memread),
    .idex_regt(regt), .branch_taken(branch), .md_start(md),
    .pcwrite(fl_a[5]), .ifid_write(fl_a[4]), .idex_write(fl_a[3]),
    .ifid_flush(fl_a[2]), .idex_flush(fl_a[1]), .exmem_flush(fl_a[0]),
    .stall_cnt_o(sc_a)
  );

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(4), .MD_LAT(1), .BR_FLUSH_EX(1)) u_b (
    .clk_i(clk), .rst_i(rst), .instr_i(instr), .idex_memread(memread),
    .idex_regt(regt), .branch_taken(branch), .md_start(md),
    .pcwrite(fl_b[5]), .ifid_write(fl_b[4]), .idex_write(fl_b[3]),
    .ifid_flush(fl_b[2]), .idex_flush(fl_b[1]), .exmem_flush(fl_b[0]),
    .stall_cnt_o(sc_b)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: remaining stall budget per instance, not a state machine.
  int ll[2] = '{3, 4};
  int ml[2] = '{4, 1};
  int bf[2] = '{1, 1};
  int ld_left[2] = '{0, 0};
  int md_left[2] = '{0, 0};
  int scm[2] = '{0, 0};

  function automatic logic hit_now();
    logic [4:0] rs;
    logic [4:0] rt;
    rs = instr[25:21];
    rt = instr[20:16];
    return memread && (regt != 5'd0) && ((regt == rs) || (regt == rt));
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic mdst, ldst, brk;
      int nld, nmd;
      logic [5:0]  exp_fl, got_fl;
      logic [15:0] got_sc;
      if (rst) begin
        ld_left[k] = 0;
        md_left[k] = 0;
        scm[k]     = 0;
      end
      mdst = 1'b0; ldst = 1'b0; brk = 1'b0;
      nld = ld_left[k]; nmd = md_left[k];
      if (md_left[k] > 0) begin
        mdst = (md_left[k] > 1);
        nmd  = md_left[k] - 1;
      end else if (ld_left[k] > 0) begin
        if (branch) begin
          brk = 1'b1;
          nld = 0;
        end else begin
          ldst = 1'b1;
          nld  = ld_left[k] - 1;
        end
      end else if (branch) begin
        brk = 1'b1;
      end else if (md && ml[k] >= 2) begin
        mdst = 1'b1;
        nmd  = ml[k] - 1;
      end else if (hit_now()) begin
        ldst = 1'b1;
        nld  = ll[k] - 1;
      end
      exp_fl = {!(mdst || ldst), !(mdst || ldst), !mdst, brk, brk || ldst,
                (brk && bf[k] != 0) || mdst};
      got_fl = (k == 0) ? fl_a : fl_b;
      got_sc = (k == 0) ? sc_a : sc_b;
      check($sformatf("model_flags_u%0d", k), 32'(got_fl), 32'(exp_fl));
      check($sformatf("model_stall_cnt_u%0d", k), 32'(got_sc), 32'(scm[k]));
      if (!rst) begin
        ld_left[k] = nld;
        md_left[k] = nmd;
        if (!exp_fl[5] && scm[k] < 65535) scm[k]++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    instr = '0; memread = 1'b0; regt = '0; branch = 1'b0; md = 1'b0;
  endtask

  initial begin
    quiet();
    rst = 1'b1;
    cyc(); cyc();
    #3;
    check("rst_flags_a", 32'(fl_a), 32'(6'b111000));
    check("rst_flags_b", 32'(fl_b), 32'(6'b111000));
    check("rst_cnt_a", 32'(sc_a), 32'd0);
    cyc();
    rst = 1'b0;

    // r0 never hazards
    memread = 1'b1; regt = 5'd0; instr = '0;
    #3;
    check("zero_reg_no_stall_a", 32'(fl_a[5]), 32'd1);
    check("zero_reg_no_stall_b", 32'(fl_b[5]), 32'd1);
    cyc(); quiet();

    // load-use on rs, LOAD_LAT=3 for u_a, 4 for u_b
    memread = 1'b1; regt = 5'd8; instr = 32'd8 << 21;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("load_pcwrite_a", 32'(fl_a[5]), 32'd0);
      check("load_idex_flush_a", 32'(fl_a[1]), 32'd1);
      cyc();
    end
    quiet();
    #3;
    check("load_release_a", 32'(fl_a[5]), 32'd1);
    check("load_cnt_a", 32'(sc_a), 32'd3);
    check("load4_still_b", 32'(fl_b[5]), 32'd0);
    cyc();
    #3;
    check("load4_release_b", 32'(fl_b[5]), 32'd1);
    check("load4_cnt_b", 32'(sc_b), 32'd4);
    cyc();

    // mul/div held 4 cycles, MD_LAT=4 on u_a, MD_LAT=1 on u_b
    md = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #3;
      check("md_idex_write_a", 32'(fl_a[3]), 32'd0);
      check("md_exmem_flush_a", 32'(fl_a[0]), 32'd1);
      check("md_lat1_no_effect_b", 32'(fl_b), 32'(6'b111000));
      cyc();
    end
    #3;
    check("md_release_a", 32'(fl_a), 32'(6'b111000));
    cyc();
    md = 1'b0;
    #3;
    check("md_no_retrigger_a", 32'(fl_a[5]), 32'd1);
    cyc();

    // branch in 2nd LOAD_STALL cycle of u_b
    memread = 1'b1; regt = 5'd8; instr = 32'd8 << 21;
    cyc(); quiet();
    cyc();
    branch = 1'b1;
    #3;
    check("br_in_load_b", 32'(fl_b), 32'(6'b111111));
    cyc(); quiet();
    #3;
    check("br_idle_next_b", 32'(fl_b), 32'(6'b111000));
    cyc();

    // all three events at once in IDLE
    branch = 1'b1; md = 1'b1; memread = 1'b1; regt = 5'd8; instr = 32'd8 << 21;
    #3;
    check("all_three_a", 32'(fl_a), 32'(6'b111111));
    cyc(); quiet();
    #3;
    check("all_three_next_a", 32'(fl_a), 32'(6'b111000));
    cyc();

    // continuous load-use via rt drives the counters into saturation
    memread = 1'b1; regt = 5'd5; instr = 32'd5 << 16;
    repeat (65540) cyc();
    #3;
    check("sat_a", 32'(sc_a), 32'hFFFF);
    check("sat_b", 32'(sc_b), 32'hFFFF);
    cyc(); cyc();
    #3;
    check("sat_hold_a", 32'(sc_a), 32'hFFFF);
    quiet();
    repeat (5) cyc();

    // reset pulse in the middle of MD_BUSY
    md = 1'b1;
    cyc();
    md = 1'b0;
    #1;
    check("md_busy_before_rst_a", 32'(fl_a[5]), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_mid_md_cnt_a", 32'(sc_a), 32'd0);
    check("rst_mid_md_flags_a", 32'(fl_a), 32'(6'b111000));
    check("rst_mid_md_cnt_b", 32'(sc_b), 32'd0);
    cyc();
    rst = 1'b0;
    #3;
    check("post_rst_idle_a", 32'(fl_a), 32'(6'b111000));
    cyc(); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
